ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
Instruction-fetch initiator that drives the combinational instruction memory. Each cycle it presents a word-aligned fetch address, captures the returned instruction word with its PC into a small prefetch FIFO, and hands entries to decode over a valid/ready handshake. A redirect input, used for branches and jumps, flushes the queue and restarts fetch at a new PC.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, at least 2
RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 0

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-high reset
imem_a  output  32  fetch address to instruction memory (= fetch_pc)
imem_rd  input  32  instruction word, combinationally valid in the same cycle as imem_a
inst_valid  output  1  head FIFO entry is valid
inst_ready  input  1  decode accepts the head entry
inst  output  32  instruction at the FIFO head
inst_pc  output  32  PC of the instruction at the FIFO head
redirect_valid  input  1  flush the queue and restart fetch
redirect_pc  input  32  new fetch PC; bits [1:0] ignored

Behaviour:
- Reset is asynchronous and active-high. It applies immediately, not at the clock edge.
- During reset:
  - fetch_pc = RESET_PC, count = 0, head and tail pointers = 0.
  - imem_a = RESET_PC, inst_valid = 0.
  - inst and inst_pc are don't-care while invalid; the bench checks them only when inst_valid = 1.
- State is fetch_pc (32b), FIFO storage of DEPTH x {pc[31:0], instr[31:0]}, head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH), and count (0..DEPTH).
- imem_a = fetch_pc, driven combinationally from the register.
- pop = inst_valid & inst_ready.
- push = !redirect_valid & (count < DEPTH | pop). Pushing when full is allowed only if a pop happens in the same cycle.
- On push, at the clock edge: write {fetch_pc, imem_rd} at tail, tail <= tail + 1, fetch_pc <= fetch_pc + 4. fetch_pc wraps from 0xFFFFFFFC to 0x00000000.
- On pop: head <= head + 1.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together.
- inst_valid = (count != 0). inst and inst_pc come from the head entry, registered with no combinational path from imem_rd.
- Latency: an address presented in cycle N appears at the head in cycle N+1 when the queue was empty. Steady-state throughput is 1 instruction per cycle.
- Full (count = DEPTH) with no pop:
  - No push.
  - fetch_pc and imem_a hold.
  - Contents are unchanged.
- Empty: inst_valid = 0. inst_ready is ignored.
- Redirect takes priority over everything at the clock edge:
  - count <= 0, head <= tail.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle. A coincident pop is discarded with the flush.
  - In the next cycle: inst_valid = 0, imem_a = the new PC.
  - One cycle later: the head holds the redirect target.
- Back-to-back redirects: the last one wins. No entry from an intermediate target becomes valid.
- inst_valid never drops while count > 0 except via redirect or reset. The head entry is stable until popped.

Test Plan:
- Reset, then release with inst_ready = 1 and memory word k = 0x1000_0000 + k -> imem_a = 0 during reset, then 0, 4, 8, ... on successive cycles; inst_pc/inst = 0/0x10000000, then 4/0x10000001 from the first edge onward.
- inst_ready held 0 from reset release -> after 4 edges inst_valid = 1, inst_pc = 0, imem_a frozen at 0x10; pulse inst_ready once -> next cycle inst_pc = 4 and imem_a = 0x14, count stays 4.
- Full queue with inst_ready = 1 for 8 cycles -> 8 pops and 8 pushes, inst_pc increments by 4 each cycle with no bubble, and the pointer wrap is correct.
- redirect_valid with redirect_pc = 0x43 while the queue is full -> next cycle inst_valid = 0 and imem_a = 0x40; following cycle inst_pc = 0x40 and inst = word 0x10.
- Redirect to 0x80, then to 0xC0 on the next cycle -> no entry with pc = 0x80 ever becomes valid; first valid inst_pc = 0xC0.
- Assert reset asynchronously mid-cycle with 3 entries queued -> inst_valid = 0 and imem_a = RESET_PC before the next edge; fetch restarts at 0 after release.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction-memory, decode and redirect signals of the fetch queue.
// Revision: 1.0
`default_nettype none

interface ifetch_queue_if;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // The fetch queue drives memory address and decode-facing outputs.
  modport master (
    output imem_a,
    input  imem_rd,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_a,
    output imem_rd,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch initiator with a DEPTH-entry prefetch FIFO and redirect flush.
// Revision: 1.0
`default_nettype none

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic pop;
  logic push;
  logic valid;

  assign valid = (count != '0);
  assign pop   = valid & bus.inst_ready;
  // Full is tolerated only when the head leaves in the same cycle.
  assign push  = !bus.redirect_valid & ((count < FULL_COUNT) | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      head     <= tail;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail     <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage holds no reset: entries are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= bus.imem_rd;
    end
  end

  assign bus.imem_a     = fetch_pc;
  assign bus.inst_valid = valid;
  assign bus.inst       = instr_mem[head];
  assign bus.inst_pc    = pc_mem[head];

endmodule

`default_nettype wire
